// File: rtl/bp_pkg.sv
// Shared definitions for the branch predictor: counter encodings, FSM states
// and the default table size.
package bp_pkg;

   localparam int unsigned BHT_ENTRIES_DEF = 64;

   localparam logic [1:0] SNT = 2'b00;
   localparam logic [1:0] WNT = 2'b01;
   localparam logic [1:0] WT  = 2'b10;
   localparam logic [1:0] ST  = 2'b11;

   typedef enum logic {
      IDLE    = 1'b0,
      PENDING = 1'b1
   } bp_state_e;

endpackage

// File: rtl/bp_sat_counter2.sv
// Next-state function of a 2-bit saturating taken/not-taken counter.
module bp_sat_counter2
   import bp_pkg::*;
(
   input  logic [1:0] cur,
   input  logic       taken,
   output logic [1:0] nxt
);

   always_comb begin
      nxt = cur;
      if (taken && (cur != ST)) begin
         nxt = cur + 2'd1;
      end else if (!taken && (cur != SNT)) begin
         nxt = cur - 2'd1;
      end
   end

endmodule

// File: rtl/branch_predict_ctrl.sv
// Bimodal branch predictor with EX-stage training and a held, handshaked
// PC redirect for misprediction recovery.
module branch_predict_ctrl
   import bp_pkg::*;
#(
   parameter int unsigned XLEN        = 64,
   parameter int unsigned BHT_ENTRIES = BHT_ENTRIES_DEF,
   parameter int unsigned IDX_W       = $clog2(BHT_ENTRIES)
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            id_valid,
   input  logic            id_is_branch,
   input  logic [XLEN-1:0] id_pc,
   output logic            id_pred_taken,
   input  logic            ex_valid,
   input  logic            ex_is_branch,
   input  logic [XLEN-1:0] ex_pc,
   input  logic            ex_pred_taken,
   input  logic            ex_taken,
   input  logic [XLEN-1:0] ex_target,
   output logic            ex_flush,
   output logic            redirect_valid,
   input  logic            redirect_ready,
   output logic [XLEN-1:0] redirect_pc,
   input  logic            perf_clr,
   output logic [31:0]     br_count,
   output logic [31:0]     mispred_count
);

   bp_state_e       state_q, state_d;
   logic [1:0]      bht_q [BHT_ENTRIES];
   logic [1:0]      bht_d [BHT_ENTRIES];
   logic [XLEN-1:0] redirect_pc_q, redirect_pc_d;
   logic [31:0]     br_count_q, br_count_d;
   logic [31:0]     mispred_count_q, mispred_count_d;

   logic [IDX_W-1:0] id_idx, ex_idx;
   logic [1:0]       ex_cnt_nxt;
   logic             res, mis;
   logic             unused_pc_bits;

   assign id_idx = id_pc[IDX_W+1:2];
   assign ex_idx = ex_pc[IDX_W+1:2];
   assign unused_pc_bits = ^{id_pc[XLEN-1:IDX_W+2], id_pc[1:0]};

   // Reads the registered table only, so a same-cycle update is not bypassed.
   assign id_pred_taken = id_valid & id_is_branch & bht_q[id_idx][1];

   assign res = ex_valid & ex_is_branch & (state_q == IDLE);
   assign mis = res & (ex_taken != ex_pred_taken);

   assign ex_flush       = mis | (state_q == PENDING);
   assign redirect_valid = (state_q == PENDING);
   assign redirect_pc    = redirect_pc_q;
   assign br_count       = br_count_q;
   assign mispred_count  = mispred_count_q;

   bp_sat_counter2 u_sat (
      .cur   (bht_q[ex_idx]),
      .taken (ex_taken),
      .nxt   (ex_cnt_nxt)
   );

   always_comb begin
      bht_d = bht_q;
      if (res) begin
         bht_d[ex_idx] = ex_cnt_nxt;
      end
   end

   always_comb begin
      state_d       = state_q;
      redirect_pc_d = redirect_pc_q;
      case (state_q)
         IDLE: begin
            if (mis) begin
               state_d       = PENDING;
               redirect_pc_d = ex_taken ? ex_target : (ex_pc + XLEN'(4));
            end
         end
         PENDING: begin
            if (redirect_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Clear wins over a same-cycle increment; both counters stick at all-ones.
   always_comb begin
      br_count_d      = br_count_q;
      mispred_count_d = mispred_count_q;
      if (perf_clr) begin
         br_count_d      = '0;
         mispred_count_d = '0;
      end else begin
         if (res && (br_count_q != '1)) begin
            br_count_d = br_count_q + 32'd1;
         end
         if (mis && (mispred_count_q != '1)) begin
            mispred_count_d = mispred_count_q + 32'd1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q         <= IDLE;
         redirect_pc_q   <= '0;
         br_count_q      <= '0;
         mispred_count_q <= '0;
         for (int unsigned i = 0; i < BHT_ENTRIES; i++) begin
            bht_q[i] <= WNT;
         end
      end else begin
         state_q         <= state_d;
         redirect_pc_q   <= redirect_pc_d;
         br_count_q      <= br_count_d;
         mispred_count_q <= mispred_count_d;
         bht_q           <= bht_d;
      end
   end

endmodule

// File: tb/tb_branch_predict_ctrl.sv
// Directed bench for branch_predict_ctrl: prediction, training, recovery
// handshake, aliasing, PC wrap, reset mid-recovery and counter boundaries.
module tb_branch_predict_ctrl;

   logic        clk = 1'b0;
   logic        reset;
   logic        id_valid, id_is_branch;
   logic [63:0] id_pc;
   logic        id_pred_taken;
   logic        ex_valid, ex_is_branch;
   logic [63:0] ex_pc;
   logic        ex_pred_taken, ex_taken;
   logic [63:0] ex_target;
   logic        ex_flush;
   logic        redirect_valid, redirect_ready;
   logic [63:0] redirect_pc;
   logic        perf_clr;
   logic [31:0] br_count, mispred_count;

   int checks = 0;
   int fails  = 0;

   branch_predict_ctrl #(.XLEN(64), .BHT_ENTRIES(64)) dut (
      .clk            (clk),
      .reset          (reset),
      .id_valid       (id_valid),
      .id_is_branch   (id_is_branch),
      .id_pc          (id_pc),
      .id_pred_taken  (id_pred_taken),
      .ex_valid       (ex_valid),
      .ex_is_branch   (ex_is_branch),
      .ex_pc          (ex_pc),
      .ex_pred_taken  (ex_pred_taken),
      .ex_taken       (ex_taken),
      .ex_target      (ex_target),
      .ex_flush       (ex_flush),
      .redirect_valid (redirect_valid),
      .redirect_ready (redirect_ready),
      .redirect_pc    (redirect_pc),
      .perf_clr       (perf_clr),
      .br_count       (br_count),
      .mispred_count  (mispred_count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic ex_drive(input logic v, input logic [63:0] pc, input logic pred,
                           input logic tk, input logic [63:0] tgt);
      ex_valid      = v;
      ex_is_branch  = v;
      ex_pc         = pc;
      ex_pred_taken = pred;
      ex_taken      = tk;
      ex_target     = tgt;
   endtask

   initial begin
      reset = 1'b1; perf_clr = 1'b0; redirect_ready = 1'b0;
      id_valid = 1'b0; id_is_branch = 1'b0; id_pc = '0;
      ex_drive(1'b0, 64'h0, 1'b0, 1'b0, 64'h0);
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;

      // Reset state
      id_valid = 1'b1; id_is_branch = 1'b1; id_pc = 64'h1000;
      #1;
      chk("rst_pred", id_pred_taken, 0);
      chk("rst_rv", redirect_valid, 0);
      chk("rst_rpc", redirect_pc, 0);
      chk("rst_br", br_count, 0);
      chk("rst_mis", mispred_count, 0);
      chk("rst_flush", ex_flush, 0);

      // Training: 01 -> 10 (mispredicted), then 10 -> 11 -> 11
      redirect_ready = 1'b1;
      ex_drive(1'b1, 64'h1000, 1'b0, 1'b1, 64'h2000);
      #1;
      chk("tr1_flush", ex_flush, 1);
      chk("tr1_pred_old", id_pred_taken, 0);
      cyc();
      ex_drive(1'b0, 64'h0, 1'b0, 1'b0, 64'h0);
      #1;
      chk("tr1_rv", redirect_valid, 1);
      chk("tr1_rpc", redirect_pc, 64'h2000);
      chk("tr1_pred", id_pred_taken, 1);
      chk("tr1_br", br_count, 1);
      chk("tr1_mis", mispred_count, 1);
      cyc();
      ex_drive(1'b1, 64'h1000, 1'b1, 1'b1, 64'h2000);
      #1;
      chk("tr2_rv", redirect_valid, 0);
      chk("tr2_flush", ex_flush, 0);
      cyc();
      cyc();
      ex_drive(1'b0, 64'h0, 1'b0, 1'b0, 64'h0);
      #1;
      chk("tr_br", br_count, 3);
      chk("tr_mis", mispred_count, 1);
      chk("tr_pred", id_pred_taken, 1);
      id_is_branch = 1'b0;
      #1;
      chk("nobr_pred", id_pred_taken, 0);
      id_is_branch = 1'b1;

      // Not-taken mispredict at 0x2FFC with ready held low
      redirect_ready = 1'b0;
      ex_drive(1'b1, 64'h2FFC, 1'b1, 1'b0, 64'h5555);
      #1;
      chk("mp_flush_det", ex_flush, 1);
      cyc();
      // Would-be mispredicts while PENDING must be ignored
      ex_drive(1'b1, 64'h1000, 1'b1, 1'b0, 64'h7000);
      for (int i = 0; i < 4; i++) begin
         if (i == 3) begin
            redirect_ready = 1'b1;
            ex_drive(1'b0, 64'h0, 1'b0, 1'b0, 64'h0);
         end
         #1;
         chk("mp_flush", ex_flush, 1);
         chk("mp_rv", redirect_valid, 1);
         chk("mp_rpc", redirect_pc, 64'h3000);
         chk("mp_br", br_count, 4);
         chk("mp_mis", mispred_count, 2);
         cyc();
      end
      #1;
      chk("mp_rv_fall", redirect_valid, 0);
      chk("mp_flush_fall", ex_flush, 0);
      chk("mp_pred_kept", id_pred_taken, 1);

      // 0x1100 aliases 0x1000: 11 -> 10 -> 01
      ex_drive(1'b1, 64'h1100, 1'b1, 1'b0, 64'h9000);
      #1;
      chk("al_flush", ex_flush, 1);
      cyc();
      ex_drive(1'b0, 64'h0, 1'b0, 1'b0, 64'h0);
      #1;
      chk("al_rpc", redirect_pc, 64'h1104);
      chk("al_pred_wt", id_pred_taken, 1);
      cyc();
      ex_drive(1'b1, 64'h1100, 1'b0, 1'b0, 64'h9000);
      #1;
      chk("al_flush2", ex_flush, 0);
      cyc();
      ex_drive(1'b0, 64'h0, 1'b0, 1'b0, 64'h0);
      #1;
      chk("al_pred_wnt", id_pred_taken, 0);
      chk("al_br", br_count, 6);
      chk("al_mis", mispred_count, 3);

      // PC + 4 wraps to zero
      redirect_ready = 1'b0;
      ex_drive(1'b1, 64'hFFFF_FFFF_FFFF_FFFC, 1'b1, 1'b0, 64'h4000);
      cyc();
      ex_drive(1'b0, 64'h0, 1'b0, 1'b0, 64'h0);
      #1;
      chk("wr_rpc", redirect_pc, 64'h0);
      chk("wr_rv", redirect_valid, 1);
      chk("wr_mis", mispred_count, 4);

      // Reset while PENDING
      reset = 1'b1;
      cyc();
      chk("rp_rv", redirect_valid, 0);
      chk("rp_br", br_count, 0);
      chk("rp_mis", mispred_count, 0);
      chk("rp_pred", id_pred_taken, 0);
      reset = 1'b0;
      ex_drive(1'b1, 64'h1000, 1'b0, 1'b1, 64'h2000);
      cyc();
      ex_drive(1'b0, 64'h0, 1'b0, 1'b0, 64'h0);
      redirect_ready = 1'b1;
      #1;
      chk("rp_pred_wnt", id_pred_taken, 1);
      chk("rp_rv2", redirect_valid, 1);
      cyc();
      chk("rp_rv3", redirect_valid, 0);

      // br_count saturation
      force dut.br_count_q = 32'hFFFF_FFFF;
      ex_drive(1'b1, 64'h1000, 1'b1, 1'b1, 64'h2000);
      #1;
      chk("sat_br_d", dut.br_count_d, 64'hFFFF_FFFF);
      cyc();
      release dut.br_count_q;
      ex_drive(1'b0, 64'h0, 1'b0, 1'b0, 64'h0);

      // perf_clr beats a same-cycle resolve and mispredict
      perf_clr = 1'b1;
      redirect_ready = 1'b0;
      ex_drive(1'b1, 64'h1000, 1'b1, 1'b0, 64'h2000);
      cyc();
      perf_clr = 1'b0;
      ex_drive(1'b0, 64'h0, 1'b0, 1'b0, 64'h0);
      redirect_ready = 1'b1;
      #1;
      chk("clr_br", br_count, 0);
      chk("clr_mis", mispred_count, 0);
      chk("clr_rv", redirect_valid, 1);
      cyc();
      chk("clr_rv_fall", redirect_valid, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
